// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types for the load/store controller: FSM states, latched request and
// the packed memory-port payloads.
package lsu_mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic              wen;
        logic              byte_not_word;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } lsu_req_s;

    typedef struct packed {
        logic              valid;
        logic              wen;
        logic              byte_not_word;
        logic [DATA_W-1:0] write_data;
        logic              yumi;
    } mem_in_s;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] read_data;
        logic              yumi;
    } mem_out_s;

    localparam int unsigned MEM_IN_W  = $bits(mem_in_s);
    localparam int unsigned MEM_OUT_W = $bits(mem_out_s);

    // Word accesses must be 4-byte aligned; byte accesses never fault.
    function automatic logic lsu_misaligned(input lsu_req_s r);
        return !r.byte_not_word && (r.addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response and memory-port signals of the load/store controller.
interface lsu_mem_ctrl_if;
    import lsu_mem_ctrl_pkg::*;

    logic                 req_valid_i;
    logic                 req_wen_i;
    logic                 req_byte_i;
    logic [ADDR_W-1:0]    req_addr_i;
    logic [DATA_W-1:0]    req_wdata_i;
    logic                 stall_o;
    logic                 resp_valid_o;
    logic [DATA_W-1:0]    resp_data_o;
    logic                 resp_err_o;
    logic                 err_sticky_o;
    logic [MEM_IN_W-1:0]  mem_port_flat_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [MEM_OUT_W-1:0] mem_port_flat_i;

    modport slave (
        input  req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i,
        input  mem_port_flat_i,
        output stall_o, resp_valid_o, resp_data_o, resp_err_o, err_sticky_o,
        output mem_port_flat_o, mem_addr_o
    );

    modport master (
        output req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i,
        output mem_port_flat_i,
        input  stall_o, resp_valid_o, resp_data_o, resp_err_o, err_sticky_o,
        input  mem_port_flat_o, mem_addr_o
    );

endinterface

// File: rtl/lsu_mem_ctrl_timeout_ctr.sv
// Transaction timeout counter: clears, counts stalled cycles, flags the last allowed one.
module lsu_timeout_ctr #(
    parameter int unsigned cnt_width_p = 5,
    parameter int unsigned timeout_p   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit_c
);

    logic [cnt_width_p-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + cnt_width_p'(1);
        end
    end

    assign o_hit_c = (r_cnt == cnt_width_p'(timeout_p - 1));

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one core memory instruction at a time onto the
// valid/yumi data-memory port, with alignment check and timeout abort.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned timeout_p   = 16,
    parameter int unsigned cnt_width_p = 5
) (
    input  logic          clk,
    input  logic          reset,
    lsu_mem_ctrl_if.slave bus
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;
    lsu_req_s          r_req;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_err_sticky;

    lsu_req_s w_new_req;
    mem_in_s  w_mem_in;
    mem_out_s w_mem_out;
    logic     w_accept;
    logic     w_misaligned;
    logic     w_advance;
    logic     w_abort;
    logic     w_capture;
    logic     w_hit;

    assign w_mem_out = mem_out_s'(bus.mem_port_flat_i);

    assign w_new_req.wen           = bus.req_wen_i;
    assign w_new_req.byte_not_word = bus.req_byte_i;
    assign w_new_req.addr          = bus.req_addr_i;
    assign w_new_req.wdata         = bus.req_wdata_i;
    assign w_misaligned            = lsu_misaligned(w_new_req);

    lsu_timeout_ctr #(
        .cnt_width_p (cnt_width_p),
        .timeout_p   (timeout_p)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .i_clr   ((r_state == IDLE) || (r_state == RESP)),
        .i_en    (((r_state == REQ) || (r_state == WAIT)) && !w_advance),
        .o_hit_c (w_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and memory-port drive; an advance always beats the timeout.
    always_comb begin
        w_state_nxt            = r_state;
        w_accept               = 1'b0;
        w_advance              = 1'b0;
        w_abort                = 1'b0;
        w_capture              = 1'b0;
        w_mem_in.valid         = 1'b0;
        w_mem_in.wen           = r_req.wen;
        w_mem_in.byte_not_word = r_req.byte_not_word;
        w_mem_in.write_data    = r_req.wdata;
        w_mem_in.yumi          = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_misaligned ? RESP : REQ;
                end
            end
            REQ: begin
                w_mem_in.valid = 1'b1;
                if (w_mem_out.yumi) begin
                    w_advance   = 1'b1;
                    w_state_nxt = WAIT;
                end else if (w_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            WAIT: begin
                if (w_mem_out.valid) begin
                    w_mem_in.yumi = 1'b1;
                    w_capture     = 1'b1;
                    w_advance     = 1'b1;
                    w_state_nxt   = RESP;
                end else if (w_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_req        <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req   <= w_new_req;
                r_rdata <= '0;
                r_err   <= w_misaligned;
                if (w_misaligned) begin
                    r_err_sticky <= 1'b1;
                end
            end
            if (w_capture) begin
                r_rdata <= r_req.wen ? '0 : w_mem_out.read_data;
            end
            if (w_abort) begin
                r_rdata      <= '0;
                r_err        <= 1'b1;
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign bus.stall_o         = bus.req_valid_i && (r_state != RESP);
    assign bus.resp_valid_o    = (r_state == RESP);
    assign bus.resp_data_o     = (r_state == RESP) ? r_rdata : '0;
    assign bus.resp_err_o      = (r_state == RESP) && r_err;
    assign bus.err_sticky_o    = r_err_sticky;
    assign bus.mem_port_flat_o = w_mem_in;
    assign bus.mem_addr_o      = r_req.addr;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller between the core's execute stage and the data memory port.
- Takes one load or store per instruction from the core, stalls the core, and drives the memory valid/yumi handshake on the packed mem_in_s / mem_out_s ports.
- Captures read data and returns a one-cycle completion.
- Rejects misaligned word accesses locally and times out unresponsive transactions.

Parameters:
timeout_p, 16, cycles allowed in REQ+WAIT combined before the transaction is aborted with an error (>=4)
cnt_width_p, 5, timeout counter width; must satisfy 2**cnt_width_p > timeout_p

Ports:
clk  in  1  single clock, all state updates on posedge
reset  in  1  synchronous, active-low: state clears at a posedge where reset==0
req_valid_i  in  1  core presents a memory instruction; held until resp_valid_o
req_wen_i  in  1  1=store, 0=load
req_byte_i  in  1  1=byte access, 0=word access
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data; byte stores use bits [7:0]
stall_o  out  1  core must hold its pipeline
resp_valid_o  out  1  one-cycle completion pulse
resp_data_o  out  32  load data, valid with resp_valid_o; 0 for stores and errors
resp_err_o  out  1  completion was an error; valid with resp_valid_o
err_sticky_o  out  1  set by any error, cleared only by reset
mem_port_flat_o  out  $bits(mem_in_s)  packed mem_in_s {valid, wen, byte_not_word, write_data, yumi}
mem_addr_o  out  32  address to memory
mem_port_flat_i  in  $bits(mem_out_s)  packed mem_out_s {valid, read_data, yumi}

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- Registered state: request fields, rdata_r, err_r, cnt_r, err_sticky_r.
- Reset values: mem valid=0, mem yumi=0, resp_valid_o=0, resp_err_o=0, resp_data_o=0, err_sticky_o=0, mem_addr_o=0. stall_o in IDLE equals req_valid_i.
- IDLE: when req_valid_i=1, latch wen/byte/addr/wdata and set cnt_r=0.
  - Word access with addr[1:0]!=0: go to RESP with err_r=1. Memory is never touched.
  - Otherwise go to REQ.
- REQ: mem.valid=1, and wen/byte_not_word/write_data/mem_addr_o come from the latched request.
  - If mem_out.yumi=1 this cycle, go to WAIT. mem.valid must be 0 from the next cycle on, so memory in IDLE is never retriggered.
- WAIT: mem.valid=0.
  - When mem_out.valid=1: drive mem.yumi=1 in the same cycle (combinational: state==WAIT & mem_out.valid), capture read_data into rdata_r (forced to 0 for stores), and go to RESP.
- RESP: resp_valid_o=1, resp_data_o=rdata_r, resp_err_o=err_r, stall_o=0. Unconditionally go to IDLE next cycle.
  - req_valid_i is ignored in RESP. The core advances on this edge, and the next instruction is accepted in IDLE.
- stall_o = req_valid_i & (state!=RESP).
- Nominal latency: accept edge to resp_valid_o is 3 cycles (IDLE, REQ, WAIT, RESP), given the memory's zero-wait yumi and one-cycle valid.
- Timeout: cnt_r increments in every REQ or WAIT cycle in which the state does not advance.
  - When cnt_r==timeout_p-1 and no advance occurs: go to RESP with err_r=1 and rdata_r=0, and set err_sticky.
  - An abort from WAIT leaves memory unacknowledged; recovery requires reset.
- Simultaneous events: if the timeout limit and an advance condition coincide, the advance wins.
- Reset mid-operation (any state): at that edge the state goes to IDLE and err_sticky/cnt clear. The next cycle has mem valid=0 and mem yumi=0, and no resp_valid_o is produced.
- Loads return memory data unmodified; memory already zero-extends byte loads.
- mem.yumi=0 in all states except WAIT. write_data is don't-care for loads but driven from the latched value.

Decomposition:
- definitions.v: add the lsu_state_e enum (IDLE/REQ/WAIT/RESP, 2-bit) and lsu_req_s (wen, byte, addr, wdata) alongside the existing mem_in_s/mem_out_s.
- Sub-module lsu_timeout_ctr: clear/enable/limit-hit, parameterised by cnt_width_p.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 → store resp_valid at +3 cycles with resp_data=0; load resp_data=0xDEADBEEF at +3; stall_o high for exactly 3 cycles per instruction.
- Byte load @0x13 after the above → resp_data=0x000000DE; mem byte_not_word=1 throughout REQ.
- Word store @0x22 → resp_valid+resp_err at accept+1, err_sticky_o=1, mem.valid never asserted.
- Memory stub withholds yumi, timeout_p=16 → resp_err after 16 REQ cycles; mem.valid drops in RESP; err_sticky_o=1.
- reset=0 asserted while in WAIT → next cycle IDLE, mem valid=0, yumi=0, err_sticky_o=0, no resp_valid_o; a fresh load then completes normally in 3 cycles.
- Back-to-back load/store/load with req_valid_i held continuously → exactly one mem.valid episode per instruction, with no duplicate memory transaction after RESP.
